// File: rtl/cpu_pkg.sv
// Constants and types shared by controller and sort_engine.
package cpu_pkg;

  localparam int DATA_W   = 4;
  localparam int ADDR_W   = 3;
  localparam int RF_DEPTH = 8;
  localparam int LEN_W    = 4;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    SORT,
    WRITE,
    DONE
  } sort_state_t;

  // Requested element count limited to the buffer depth.
  function automatic logic [LEN_W-1:0] clamp_len(
    input logic [LEN_W-1:0] len,
    input logic [LEN_W-1:0] max_len
  );
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/sort_buffer.sv
// Local element buffer: two capture ports, one compare-swap port, one read port.
module sort_buffer #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic                     wr0_en,
  input  logic [$clog2(DEPTH)-1:0] wr0_idx,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [$clog2(DEPTH)-1:0] wr1_idx,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     swap_en,
  input  logic [$clog2(DEPTH)-1:0] swap_idx,
  input  logic                     descending,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [DATA_W-1:0]        rd_data
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] lo;
  logic [DATA_W-1:0] hi;
  logic              do_swap;

  // Neighbour pair at swap_idx and whether it is out of order (equal never swaps).
  always_comb begin
    lo      = mem[swap_idx];
    hi      = mem[swap_idx + IDX_W'(1)];
    do_swap = descending ? (hi > lo) : (hi < lo);
  end

  assign rd_data = mem[rd_idx];

  // Storage update: synchronous clear, capture writes, compare-swap.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int unsigned n = 0; n < DEPTH; n++) begin
        mem[n] <= '0;
      end
    end else begin
      if (wr0_en) mem[wr0_idx] <= wr0_data;
      if (wr1_en) mem[wr1_idx] <= wr1_data;
      if (swap_en && do_swap) begin
        mem[swap_idx]              <= hi;
        mem[swap_idx + IDX_W'(1)]  <= lo;
      end
    end
  end

endmodule

// File: rtl/sort_engine.sv
// Register-file sort sequencer: read range, bubble-sort locally, write back.
module sort_engine #(
  parameter int DATA_W  = cpu_pkg::DATA_W,
  parameter int ADDR_W  = cpu_pkg::ADDR_W,
  parameter int MAX_LEN = cpu_pkg::RF_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              descending,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [3:0]        length,
  output logic [ADDR_W-1:0] rf_read_address1,
  output logic [ADDR_W-1:0] rf_read_address2,
  input  logic [DATA_W-1:0] rf_read_data1,
  input  logic [DATA_W-1:0] rf_read_data2,
  output logic [ADDR_W-1:0] rf_write_address,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_write_enable,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] last_written
);

  import cpu_pkg::*;

  localparam int IDX_W = $clog2(MAX_LEN);

  sort_state_t       state;
  sort_state_t       state_d;
  logic              desc_q;
  logic [ADDR_W-1:0] dst_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  len_in;
  logic [LEN_W-1:0]  pairs;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  cap_base;
  logic [IDX_W-1:0]  i_q;
  logic [IDX_W-1:0]  j_q;
  logic              j_last;
  logic              i_last;
  logic              cap_en;
  logic [DATA_W-1:0] buf_rd;

  assign len_in   = clamp_len(length, LEN_W'(MAX_LEN));
  assign pairs    = (len_q + LEN_W'(1)) >> 1;
  assign cap_base = (cnt - LEN_W'(1)) << 1;
  assign j_last   = (LEN_W'(j_q) == len_q - LEN_W'(2) - LEN_W'(i_q));
  assign i_last   = (LEN_W'(i_q) == len_q - LEN_W'(2));
  assign cap_en   = (state == READ) && (cnt != '0);

  // READ cycle cnt captures the pair addressed in cycle cnt-1; the odd tail slot is dropped.
  sort_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (MAX_LEN)
  ) u_buf (
    .clk        (clk),
    .clear      (reset),
    .wr0_en     (cap_en),
    .wr0_idx    (IDX_W'(cap_base)),
    .wr0_data   (rf_read_data1),
    .wr1_en     (cap_en && (cap_base + LEN_W'(1) < len_q)),
    .wr1_idx    (IDX_W'(cap_base + LEN_W'(1))),
    .wr1_data   (rf_read_data2),
    .swap_en    (state == SORT),
    .swap_idx   (j_q),
    .descending (desc_q),
    .rd_idx     (IDX_W'(cnt)),
    .rd_data    (buf_rd)
  );

  // Next-state selection.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (start) state_d = (len_in == '0) ? DONE : READ;
      READ:    if (cnt == pairs) state_d = (len_q == LEN_W'(1)) ? WRITE : SORT;
      SORT:    if (j_last && i_last) state_d = WRITE;
      WRITE:   if (cnt == len_q - LEN_W'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status and write-back port, all zero outside their active states.
  always_comb begin
    busy             = (state != IDLE);
    done             = (state == DONE);
    rf_write_enable  = (state == WRITE);
    rf_write_address = '0;
    rf_write_data    = '0;
    if (state == WRITE) begin
      rf_write_address = dst_q + ADDR_W'(cnt);
      rf_write_data    = buf_rd;
    end
  end

  // State register, latched parameters, counters and read-address pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      desc_q           <= 1'b0;
      dst_q            <= '0;
      len_q            <= '0;
      cnt              <= '0;
      i_q              <= '0;
      j_q              <= '0;
      rf_read_address1 <= '0;
      rf_read_address2 <= '0;
      last_written     <= '0;
    end else begin
      state <= state_d;
      unique case (state)
        IDLE: begin
          if (start) begin
            desc_q <= descending;
            dst_q  <= dst_base;
            len_q  <= len_in;
            cnt    <= '0;
            i_q    <= '0;
            j_q    <= '0;
            if (len_in != '0) begin
              rf_read_address1 <= src_base;
              rf_read_address2 <= src_base + ADDR_W'(1);
            end
          end
        end
        READ: begin
          if (cnt + LEN_W'(1) < pairs) begin
            rf_read_address1 <= rf_read_address1 + ADDR_W'(2);
            rf_read_address2 <= rf_read_address2 + ADDR_W'(2);
          end
          cnt <= (cnt == pairs) ? '0 : cnt + LEN_W'(1);
        end
        SORT: begin
          if (j_last) begin
            j_q <= '0;
            i_q <= i_q + IDX_W'(1);
          end else begin
            j_q <= j_q + IDX_W'(1);
          end
        end
        WRITE: begin
          last_written <= buf_rd;
          cnt          <= cnt + LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_engine.sv
// Self-checking bench for sort_engine with a behavioural register file and sort model.
module tb_sort_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       descending = 1'b0;
  logic [2:0] src_base = '0;
  logic [2:0] dst_base = '0;
  logic [3:0] length = '0;
  logic [2:0] rf_read_address1;
  logic [2:0] rf_read_address2;
  logic [3:0] rf_read_data1;
  logic [3:0] rf_read_data2;
  logic [2:0] rf_write_address;
  logic [3:0] rf_write_data;
  logic       rf_write_enable;
  logic       busy;
  logic       done;
  logic [3:0] last_written;

  logic [3:0] rf     [8];
  logic [3:0] ld_img [8];
  logic       ld_go = 1'b0;
  logic [3:0] model  [8];
  logic [3:0] lw_model;

  int total = 0;
  int bad = 0;
  int wr_count = 0;
  int done_count = 0;

  sort_engine #(
    .DATA_W  (4),
    .ADDR_W  (3),
    .MAX_LEN (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .descending       (descending),
    .src_base         (src_base),
    .dst_base         (dst_base),
    .length           (length),
    .rf_read_address1 (rf_read_address1),
    .rf_read_address2 (rf_read_address2),
    .rf_read_data1    (rf_read_data1),
    .rf_read_data2    (rf_read_data2),
    .rf_write_address (rf_write_address),
    .rf_write_data    (rf_write_data),
    .rf_write_enable  (rf_write_enable),
    .busy             (busy),
    .done             (done),
    .last_written     (last_written)
  );

  always #5 clk = ~clk;

  // Register file with registered read ports; also counts strobes and done pulses.
  always @(posedge clk) begin
    rf_read_data1 <= rf[rf_read_address1];
    rf_read_data2 <= rf[rf_read_address2];
    if (ld_go) begin
      rf <= ld_img;
    end else if (rf_write_enable) begin
      rf[rf_write_address] <= rf_write_data;
    end
    if (rf_write_enable) wr_count <= wr_count + 1;
    if (done) done_count <= done_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_rf(input logic [3:0] v0, v1, v2, v3, v4, v5, v6, v7);
    ld_img[0] = v0; ld_img[1] = v1; ld_img[2] = v2; ld_img[3] = v3;
    ld_img[4] = v4; ld_img[5] = v5; ld_img[6] = v6; ld_img[7] = v7;
    for (int r = 0; r < 8; r++) model[r] = ld_img[r];
    ld_go = 1'b1;
    @(posedge clk); #1;
    ld_go = 1'b0;
  endtask

  task automatic check_rf(input string tag);
    for (int r = 0; r < 8; r++) begin
      check($sformatf("%s_r%0d", tag, r), 32'(rf[r]), 32'(model[r]));
    end
  endtask

  // One sort from the model's point of view; poke>0 re-pulses start while busy.
  task automatic run_sort(input int src, input int dst, input int len, input bit desc,
                          input int poke, input string tag);
    int L;
    int exp_n;
    int got_n;
    int w0;
    int d0;
    logic [3:0] q[$];
    L = (len > 8) ? 8 : len;
    exp_n = (L == 0) ? 1 : 1 + ((L + 1) / 2 + 1) + (L * (L - 1)) / 2 + L;
    for (int k = 0; k < L; k++) q.push_back(model[(src + k) % 8]);
    if (desc) q.rsort(); else q.sort();
    w0 = wr_count;
    d0 = done_count;
    src_base = 3'(src);
    dst_base = 3'(dst);
    length = 4'(len);
    descending = desc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got_n = 0;
    for (int c = 1; c <= 100; c++) begin
      if (c == 1) check({tag, "_busy_rise"}, 32'(busy), 32'd1);
      if (done) begin
        got_n = c;
        break;
      end
      if (poke != 0 && c == poke) begin
        start = 1'b1;
        src_base = 3'(src + 3);
        dst_base = 3'(dst + 1);
        length = 4'd2;
        descending = ~desc;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, 32'(got_n), 32'(exp_n));
    for (int k = 0; k < L; k++) model[(dst + k) % 8] = q[k];
    if (L > 0) lw_model = q[L - 1];
    @(posedge clk); #1;
    check({tag, "_busy_fall"}, 32'(busy), 32'd0);
    if (poke != 0) begin
      repeat (30) @(posedge clk);
      #1;
    end
    check({tag, "_writes"}, 32'(wr_count - w0), 32'(L));
    check({tag, "_done_pulses"}, 32'(done_count - d0), 32'd1);
    check({tag, "_last_written"}, 32'(last_written), 32'(lw_model));
    check_rf(tag);
  endtask

  initial begin
    int w0;
    int d0;
    lw_model = '0;
    for (int r = 0; r < 8; r++) begin
      rf[r] = '0;
      ld_img[r] = '0;
      model[r] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_we", 32'(rf_write_enable), 32'd0);
    check("rst_waddr", 32'(rf_write_address), 32'd0);
    check("rst_wdata", 32'(rf_write_data), 32'd0);
    check("rst_raddr1", 32'(rf_read_address1), 32'd0);
    check("rst_raddr2", 32'(rf_read_address2), 32'd0);
    check("rst_last", 32'(last_written), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    load_rf(5, 3, 7, 1, 0, 0, 0, 0);
    run_sort(0, 4, 4, 1'b0, 0, "asc_copy");
    run_sort(4, 4, 4, 1'b0, 0, "presorted");
    load_rf(5, 3, 7, 1, 0, 0, 0, 0);
    run_sort(0, 0, 4, 1'b1, 0, "des_inplace");
    load_rf(4, 0, 0, 0, 0, 0, 9, 2);
    run_sort(6, 6, 3, 1'b0, 0, "wrap_odd");
    run_sort(2, 5, 0, 1'b0, 0, "len0");
    run_sort(6, 1, 1, 1'b1, 0, "len1");
    load_rf(6, 15, 0, 8, 3, 12, 1, 9);
    run_sort(3, 3, 12, 1'b0, 0, "len12");
    load_rf(3, 3, 1, 3, 7, 7, 7, 7);
    run_sort(0, 0, 4, 1'b0, 0, "dups");
    load_rf(9, 2, 14, 5, 0, 11, 6, 3);
    run_sort(1, 2, 4, 1'b0, 4, "start_busy");

    // Abort during SORT: idle next cycle with zeroed outputs, nothing more happens.
    load_rf(8, 1, 6, 2, 15, 4, 0, 3);
    w0 = wr_count;
    d0 = done_count;
    src_base = 3'd0;
    dst_base = 3'd0;
    length = 4'd8;
    descending = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    lw_model = '0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_we", 32'(rf_write_enable), 32'd0);
    check("abort_raddr1", 32'(rf_read_address1), 32'd0);
    check("abort_last", 32'(last_written), 32'd0);
    repeat (60) @(posedge clk);
    #1;
    check("abort_writes", 32'(wr_count - w0), 32'd0);
    check("abort_done_pulses", 32'(done_count - d0), 32'd0);
    check_rf("abort");

    for (int t = 0; t < 16; t++) begin
      load_rf(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
              4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      run_sort(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 15)), 1'($urandom), 0, $sformatf("rnd%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
